// File: rtl/pbs_pkg.sv
// Shared types and constants for the PBS turn engine: turn states, the fixed
// move table, the LFSR feedback mask and saturating HP arithmetic.
package pbs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P_ATK   = 2'd1,
    AI_ATK  = 2'd2,
    RESOLVE = 2'd3
  } turn_state_t;

  localparam int NUM_MOVES = 4;
  localparam int MOVE_DMG [NUM_MOVES] = '{4, 6, 8, 2};
  localparam int MOVE_ACC [NUM_MOVES] = '{12, 9, 5, 15};

  // Galois feedback for x^16+x^14+x^13+x^11+1 in a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned sat_sub(input int unsigned hp, input int unsigned dmg);
    return (dmg >= hp) ? 0 : hp - dmg;
  endfunction

endpackage

// File: rtl/pbs_turn_engine_if.sv
// Turn request/result bundle between the game FSM (master) and the turn
// engine (slave).
interface pbs_turn_engine_if #(
  parameter int HP_W   = 4,
  parameter int MOVE_W = 2
);
  logic              start;
  logic              new_game;
  logic [MOVE_W-1:0] p_move;
  logic              ready;
  logic              done;
  logic [HP_W-1:0]   p_hp;
  logic [HP_W-1:0]   ai_hp;
  logic              p_dead;
  logic              ai_dead;
  logic [MOVE_W-1:0] ai_move;
  logic              p_hit;
  logic              ai_hit;

  modport master (
    output start, new_game, p_move,
    input  ready, done, p_hp, ai_hp, p_dead, ai_dead, ai_move, p_hit, ai_hit
  );

  modport slave (
    input  start, new_game, p_move,
    output ready, done, p_hp, ai_hp, p_dead, ai_dead, ai_move, p_hit, ai_hit
  );
endinterface

// File: rtl/pbs_lfsr.sv
// Free-running 16-bit Galois LFSR; the random source for hit, crit and AI
// move rolls.
module pbs_lfsr
  import pbs_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/pbs_turn_engine.sv
// PBS battle turn sequencer: player attack, AI attack, resolve per start.
// Define PBS_CRIT_EN to let the LFSR crit bit double the damage of a hit.
module pbs_turn_engine
  import pbs_pkg::*;
#(
  parameter int          HP_W      = 4,
  parameter int          DMG_W     = 4,
  parameter int          MOVE_W    = 2,
  parameter int          RNG_W     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  pbs_turn_engine_if.slave   bus
);

  function automatic logic [DMG_W-1:0] dmg_of(input logic [MOVE_W-1:0] m);
    return DMG_W'(MOVE_DMG[int'(m) % NUM_MOVES]);
  endfunction

  function automatic logic [RNG_W-1:0] acc_of(input logic [MOVE_W-1:0] m);
    return RNG_W'(MOVE_ACC[int'(m) % NUM_MOVES]);
  endfunction

  logic [15:0]       lfsr;
  turn_state_t       state;
  logic [HP_W-1:0]   p_hp_reg;
  logic [HP_W-1:0]   ai_hp_reg;
  logic [MOVE_W-1:0] p_move_reg;
  logic [MOVE_W-1:0] ai_move_reg;
  logic              done_reg;
  logic              p_hit_reg;
  logic              ai_hit_reg;

  logic              p_dead;
  logic              ai_dead;
  logic              ready;

  logic [MOVE_W-1:0] atk_move;
  logic [HP_W-1:0]   tgt_hp;
  logic [RNG_W-1:0]  atk_acc;
  logic              atk_hit;
  logic [DMG_W:0]    eff_dmg;
  logic [HP_W-1:0]   new_hp;
  logic              unused_lfsr;

  pbs_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign unused_lfsr = ^lfsr;

  assign p_dead  = (p_hp_reg == '0);
  assign ai_dead = (ai_hp_reg == '0);
  assign ready   = (state == IDLE) && !p_dead && !ai_dead;

  // One attack datapath, shared by both attack states; target and move swap.
  always_comb begin
    atk_move = (state == P_ATK) ? p_move_reg : ai_move_reg;
    tgt_hp   = (state == P_ATK) ? ai_hp_reg : p_hp_reg;
    atk_acc  = acc_of(atk_move);
    atk_hit  = (atk_acc == {RNG_W{1'b1}}) || (lfsr[RNG_W-1:0] < atk_acc);
    eff_dmg  = {1'b0, dmg_of(atk_move)};
`ifdef PBS_CRIT_EN
    if (lfsr[15]) begin
      eff_dmg = {dmg_of(atk_move), 1'b0};
    end
`endif
    new_hp = atk_hit ? HP_W'(sat_sub(32'(tgt_hp), 32'(eff_dmg))) : tgt_hp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      p_hp_reg    <= '1;
      ai_hp_reg   <= '1;
      p_move_reg  <= '0;
      ai_move_reg <= '0;
      done_reg    <= 1'b0;
      p_hit_reg   <= 1'b0;
      ai_hit_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && ready) begin
            p_move_reg <= bus.p_move;
            p_hit_reg  <= 1'b0;
            ai_hit_reg <= 1'b0;
            state      <= P_ATK;
          end else if (bus.new_game) begin
            p_hp_reg  <= '1;
            ai_hp_reg <= '1;
          end
        end
        P_ATK: begin
          ai_hp_reg   <= new_hp;
          p_hit_reg   <= atk_hit;
          ai_move_reg <= lfsr[RNG_W +: MOVE_W];
          // A defeated AI skips its attack entirely.
          if (new_hp == '0) begin
            done_reg <= 1'b1;
            state    <= RESOLVE;
          end else begin
            state <= AI_ATK;
          end
        end
        AI_ATK: begin
          p_hp_reg   <= new_hp;
          ai_hit_reg <= atk_hit;
          done_reg   <= 1'b1;
          state      <= RESOLVE;
        end
        RESOLVE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready   = ready;
  assign bus.done    = done_reg;
  assign bus.p_hp    = p_hp_reg;
  assign bus.ai_hp   = ai_hp_reg;
  assign bus.p_dead  = p_dead;
  assign bus.ai_dead = ai_dead;
  assign bus.ai_move = ai_move_reg;
  assign bus.p_hit   = p_hit_reg;
  assign bus.ai_hit  = ai_hit_reg;

endmodule

// File: tb/tb_pbs_turn_engine.sv
// Scoreboard bench for pbs_turn_engine: a reference LFSR and turn model
// predict each turn; results are compared when done pulses.
module tb_pbs_turn_engine;

  localparam int          HP_W   = 4;
  localparam int          DMG_W  = 4;
  localparam int          MOVE_W = 2;
  localparam int          RNG_W  = 4;
  localparam logic [15:0] SEED   = 16'hACE1;

  localparam int TB_DMG [4] = '{4, 6, 8, 2};
  localparam int TB_ACC [4] = '{12, 9, 5, 15};

  typedef struct {
    int lat;
    int p_hp;
    int ai_hp;
    int ai_move;
    bit p_hit;
    bit ai_hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pbs_turn_engine_if #(.HP_W(HP_W), .MOVE_W(MOVE_W)) bus ();

  pbs_turn_engine #(
    .HP_W(HP_W), .DMG_W(DMG_W), .MOVE_W(MOVE_W), .RNG_W(RNG_W), .LFSR_SEED(SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] m_lfsr;
  exp_t        sb [$];
  int          exp_p_hp  = 15;
  int          exp_ai_hp = 15;
  int          n_checks  = 0;
  int          n_fail    = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic int hp_after(input int hp, input int d);
    return (d >= hp) ? 0 : hp - d;
  endfunction

  // s1 is the LFSR value during P_ATK, s2 during AI_ATK.
  function automatic exp_t predict(input int pm, input int php, input int aihp,
                                   input logic [15:0] s1, input logic [15:0] s2);
    exp_t e;
    int   d;
    int   am;
    am        = int'(s1[5:4]);
    e.ai_move = am;
    e.p_hit   = (TB_ACC[pm] == 15) || (int'(s1[3:0]) < TB_ACC[pm]);
    d         = TB_DMG[pm];
`ifdef PBS_CRIT_EN
    if (s1[15]) d = 2 * d;
`endif
    e.ai_hp  = e.p_hit ? hp_after(aihp, d) : aihp;
    e.p_hp   = php;
    e.ai_hit = 1'b0;
    e.lat    = 2;
    if (e.ai_hp != 0) begin
      e.lat    = 3;
      e.ai_hit = (TB_ACC[am] == 15) || (int'(s2[3:0]) < TB_ACC[am]);
      d        = TB_DMG[am];
`ifdef PBS_CRIT_EN
      if (s2[15]) d = 2 * d;
`endif
      if (e.ai_hit) e.p_hp = hp_after(php, d);
    end
    return e;
  endfunction

  function automatic exp_t predict_now(input int pm);
    return predict(pm, exp_p_hp, exp_ai_hp, lfsr_next(m_lfsr), lfsr_next(lfsr_next(m_lfsr)));
  endfunction

  task automatic run_turn(input int pm, input bit with_new_game);
    exp_t e;
    int   cyc;
    bit   seen;
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_start: got %b want 1", bus.ready);
    end
    sb.push_back(predict_now(pm));
    bus.p_move   = MOVE_W'(pm);
    bus.start    = 1'b1;
    bus.new_game = with_new_game;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.new_game = 1'b0;
    bus.p_move   = MOVE_W'($urandom_range(0, 3));
    cyc = 1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.p_hit !== 1'b0 || bus.ai_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_start: ready=%b p_hit=%b ai_hit=%b want 0/0/0",
               bus.ready, bus.p_hit, bus.ai_hit);
    end
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    e = sb.pop_front();
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, want %0d", cyc, e.lat);
    end else begin
      if (cyc != e.lat) begin
        n_fail++;
        $display("FAIL latency: got %0d want %0d", cyc, e.lat);
      end
      n_checks++;
      if (bus.ai_hp !== HP_W'(e.ai_hp) || bus.p_hp !== HP_W'(e.p_hp)) begin
        n_fail++;
        $display("FAIL hp: got p=%0d ai=%0d want p=%0d ai=%0d", bus.p_hp, bus.ai_hp, e.p_hp, e.ai_hp);
      end
      n_checks++;
      if (bus.p_hit !== e.p_hit || bus.ai_hit !== e.ai_hit || bus.ai_move !== MOVE_W'(e.ai_move)) begin
        n_fail++;
        $display("FAIL hits_move: got p_hit=%b ai_hit=%b ai_move=%0d want %b %b %0d",
                 bus.p_hit, bus.ai_hit, bus.ai_move, e.p_hit, e.ai_hit, e.ai_move);
      end
      n_checks++;
      if (bus.p_dead !== (e.p_hp == 0) || bus.ai_dead !== (e.ai_hp == 0)) begin
        n_fail++;
        $display("FAIL dead_flags: got p=%b ai=%b want p=%b ai=%b",
                 bus.p_dead, bus.ai_dead, e.p_hp == 0, e.ai_hp == 0);
      end
    end
    exp_p_hp  = e.p_hp;
    exp_ai_hp = e.ai_hp;
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.ready !== (exp_p_hp != 0 && exp_ai_hp != 0)) begin
      n_fail++;
      $display("FAIL after_resolve: done=%b ready=%b want done=0 ready=%b",
               bus.done, bus.ready, exp_p_hp != 0 && exp_ai_hp != 0);
    end
    $display("turn move=%0d lat=%0d -> p_hp=%0d ai_hp=%0d p_hit=%b ai_hit=%b ai_move=%0d",
             pm, cyc, bus.p_hp, bus.ai_hp, bus.p_hit, bus.ai_hit, bus.ai_move);
  endtask

  task automatic do_new_game();
    bus.new_game = 1'b1;
    @(posedge clk); #1;
    bus.new_game = 1'b0;
    exp_p_hp  = 15;
    exp_ai_hp = 15;
    n_checks++;
    if (bus.p_hp !== 4'd15 || bus.ai_hp !== 4'd15 || bus.ready !== 1'b1 || bus.ai_dead !== 1'b0) begin
      n_fail++;
      $display("FAIL new_game: got p=%0d ai=%0d ready=%b ai_dead=%b want 15 15 1 0",
               bus.p_hp, bus.ai_hp, bus.ready, bus.ai_dead);
    end
    $display("new_game -> p_hp=%0d ai_hp=%0d ready=%b", bus.p_hp, bus.ai_hp, bus.ready);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.p_hp !== 4'd15 || bus.ai_hp !== 4'd15) begin
      n_fail++;
      $display("FAIL reset_hp: got p=%0d ai=%0d want 15 15", bus.p_hp, bus.ai_hp);
    end
    n_checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b done=%b want 1 0", bus.ready, bus.done);
    end
    n_checks++;
    if (bus.p_hit !== 1'b0 || bus.ai_hit !== 1'b0 || bus.ai_move !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_turn: got p_hit=%b ai_hit=%b ai_move=%0d want 0 0 0",
               bus.p_hit, bus.ai_hit, bus.ai_move);
    end
    $display("reset -> p_hp=%0d ai_hp=%0d ready=%b", bus.p_hp, bus.ai_hp, bus.ready);
  endtask

  task automatic test_one_turn();
    run_turn(3, 1'b0);
  endtask

  // Wait until the next turn lands a plain (non-crit) hit and the AI misses.
  task automatic steer_quiet_turn();
    exp_t e;
    bit   ok;
    ok = 1'b0;
    for (int w = 0; w < 64 && !ok; w++) begin
      e = predict_now(3);
      if (e.ai_hit == 1'b0 && (e.ai_hp == exp_ai_hp - 2 || e.ai_hp == 0)) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL steer_timeout: no quiet turn within 64 cycles");
    end
  endtask

  task automatic test_ai_death();
    do_new_game();
    for (int t = 0; t < 7; t++) begin
      steer_quiet_turn();
      run_turn(3, 1'b0);
    end
    n_checks++;
    if (bus.ai_hp !== 4'd1 || bus.p_hp !== 4'd15) begin
      n_fail++;
      $display("FAIL seven_turns: got ai=%0d p=%0d want 1 15", bus.ai_hp, bus.p_hp);
    end
    steer_quiet_turn();
    run_turn(3, 1'b0);
    n_checks++;
    if (bus.ai_hp !== 4'd0 || bus.ai_dead !== 1'b1 || bus.ai_hit !== 1'b0 ||
        bus.p_hp !== 4'd15 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ai_death: ai=%0d dead=%b ai_hit=%b p=%0d ready=%b want 0 1 0 15 0",
               bus.ai_hp, bus.ai_dead, bus.ai_hit, bus.p_hp, bus.ready);
    end
  endtask

  task automatic test_dead_ignore();
    int dones;
    dones = 0;
    bus.start  = 1'b1;
    bus.p_move = 2'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (dones != 0 || bus.ai_hp !== 4'd0 || bus.p_hp !== HP_W'(exp_p_hp) || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL dead_start: dones=%0d ai=%0d p=%0d ready=%b want 0 0 %0d 0",
               dones, bus.ai_hp, bus.p_hp, bus.ready, exp_p_hp);
    end
    $display("start while dead -> dones=%0d ready=%b", dones, bus.ready);
    do_new_game();
  endtask

  task automatic test_start_priority();
    run_turn(3, 1'b0);
    if (exp_p_hp == 0 || exp_ai_hp == 0) do_new_game();
    // Start and new_game together: the turn runs on the current HP.
    run_turn(0, 1'b1);
  endtask

  task automatic test_reset_mid_turn();
    do_new_game();
    bus.p_move = 2'd3;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.p_hp !== 4'd15 || bus.ai_hp !== 4'd15 || bus.done !== 1'b0 || bus.p_hit !== 1'b0 ||
        bus.ai_hit !== 1'b0 || bus.ai_move !== 2'd0 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: p=%0d ai=%0d done=%b p_hit=%b ai_hit=%b ai_move=%0d ready=%b want reset values",
               bus.p_hp, bus.ai_hp, bus.done, bus.p_hit, bus.ai_hit, bus.ai_move, bus.ready);
    end
    $display("reset during AI_ATK -> p_hp=%0d ai_hp=%0d ready=%b", bus.p_hp, bus.ai_hp, bus.ready);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_p_hp  = 15;
    exp_ai_hp = 15;
    run_turn(1, 1'b0);
  endtask

  task automatic test_crit();
    logic [15:0] s1;
    bit          ok;
    do_new_game();
    ok = 1'b0;
    for (int w = 0; w < 64 && !ok; w++) begin
      s1 = lfsr_next(m_lfsr);
      if (s1[15]) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    run_turn(3, 1'b0);
    n_checks++;
`ifdef PBS_CRIT_EN
    if (!ok || bus.ai_hp !== 4'd11) begin
      n_fail++;
      $display("FAIL crit_hit: ok=%b ai=%0d want ai=11", ok, bus.ai_hp);
    end
`else
    if (!ok || bus.ai_hp !== 4'd13) begin
      n_fail++;
      $display("FAIL crit_ignored: ok=%b ai=%0d want ai=13", ok, bus.ai_hp);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 10; t++) begin
      if (bus.ready !== 1'b1) do_new_game();
      run_turn($urandom_range(0, 3), 1'b0);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.new_game = 1'b0;
    bus.p_move   = '0;
    test_reset();
    test_one_turn();
    test_ai_death();
    test_dead_ignore();
    test_start_priority();
    test_reset_mid_turn();
    test_crit();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
